// File: rtl/pingpong_frame_buf.sv
// Multi-bank ping-pong frame buffer: whole frames are stored into a bank and
// handed to the reader only once closed, so the consumer sees gap-free frames.
`timescale 1ns/1ps

module pingpong_frame_buf #(
  parameter int unsigned BANK_NUM   = 2,
  parameter int unsigned BANK_DEPTH = 16,
  parameter int unsigned DATA_WD    = 8
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           flush,
  input  logic                           in_valid,
  input  logic [DATA_WD-1:0]             in_data,
  input  logic                           in_last,
  output logic                           in_ready,
  output logic                           out_valid,
  output logic [DATA_WD-1:0]             out_data,
  output logic                           out_last,
  input  logic                           out_ready,
  output logic [$clog2(BANK_NUM+1)-1:0]  bank_cnt,
  output logic                           trunc
);

  localparam int unsigned AW = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
  localparam int unsigned BW = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;
  localparam int unsigned LW = $clog2(BANK_DEPTH + 1);
  localparam int unsigned CW = $clog2(BANK_NUM + 1);

  logic [DATA_WD-1:0]  r_mem [BANK_NUM][BANK_DEPTH];
  logic [LW-1:0]       r_len [BANK_NUM];
  logic [BANK_NUM-1:0] r_full;
  logic [BW-1:0]       r_wr_bank;
  logic [AW-1:0]       r_wr_addr;
  logic [BW-1:0]       r_rd_bank;
  logic [AW-1:0]       r_rd_addr;
  logic [CW-1:0]       r_bank_cnt;
  logic                r_trunc;

  logic                w_fire_in;
  logic                w_fire_out;
  logic                w_wr_end;
  logic                w_close;
  logic                w_release;
  logic [BW-1:0]       w_wr_bank_nxt;
  logic [BW-1:0]       w_rd_bank_nxt;
  logic [BANK_NUM-1:0] w_set;
  logic [BANK_NUM-1:0] w_clr;

  assign in_ready  = ~r_full[r_wr_bank];
  assign out_valid = r_full[r_rd_bank];
  assign out_data  = r_mem[r_rd_bank][r_rd_addr];
  assign out_last  = out_valid & ((LW'(r_rd_addr) + LW'(1)) == r_len[r_rd_bank]);
  assign bank_cnt  = r_bank_cnt;
  assign trunc     = r_trunc;

  // Handshakes and bank open/close events
  always_comb begin
    w_fire_in     = in_valid & in_ready;
    w_fire_out    = out_valid & out_ready;
    w_wr_end      = (r_wr_addr == AW'(BANK_DEPTH - 1));
    w_close       = w_fire_in & (in_last | w_wr_end);
    w_release     = w_fire_out & out_last;
    w_wr_bank_nxt = (r_wr_bank == BW'(BANK_NUM - 1)) ? '0 : r_wr_bank + BW'(1);
    w_rd_bank_nxt = (r_rd_bank == BW'(BANK_NUM - 1)) ? '0 : r_rd_bank + BW'(1);
    w_set         = w_close   ? (BANK_NUM'(1) << r_wr_bank) : '0;
    w_clr         = w_release ? (BANK_NUM'(1) << r_rd_bank) : '0;
  end

  // Control state; flush discards every same-cycle handshake update
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_full     <= '0;
      r_wr_bank  <= '0;
      r_wr_addr  <= '0;
      r_rd_bank  <= '0;
      r_rd_addr  <= '0;
      r_bank_cnt <= '0;
      r_trunc    <= 1'b0;
    end else if (flush) begin
      r_full     <= '0;
      r_wr_bank  <= '0;
      r_wr_addr  <= '0;
      r_rd_bank  <= '0;
      r_rd_addr  <= '0;
      r_bank_cnt <= '0;
      r_trunc    <= 1'b0;
    end else begin
      r_full  <= (r_full | w_set) & ~w_clr;
      r_trunc <= w_close & ~in_last;
      if (w_fire_in) begin
        if (w_close) begin
          r_wr_addr <= '0;
          r_wr_bank <= w_wr_bank_nxt;
        end else begin
          r_wr_addr <= r_wr_addr + AW'(1);
        end
      end
      if (w_fire_out) begin
        if (out_last) begin
          r_rd_addr <= '0;
          r_rd_bank <= w_rd_bank_nxt;
        end else begin
          r_rd_addr <= r_rd_addr + AW'(1);
        end
      end
      if (w_close && !w_release) begin
        r_bank_cnt <= r_bank_cnt + CW'(1);
      end else if (!w_close && w_release) begin
        r_bank_cnt <= r_bank_cnt - CW'(1);
      end
    end
  end

  // Frame storage and lengths are not reset; they are only read from full banks
  always_ff @(posedge clk) begin
    if (w_fire_in && !flush) begin
      r_mem[r_wr_bank][r_wr_addr] <= in_data;
    end
    if (w_close && !flush) begin
      r_len[r_wr_bank] <= LW'(r_wr_addr) + LW'(1);
    end
  end

endmodule

// File: tb/tb_pingpong_frame_buf.sv
// Directed bench for pingpong_frame_buf: frame pass-through, backpressure,
// truncation, 1-beat streaming, flush and asynchronous reset.
`timescale 1ns/1ps

module tb_pingpong_frame_buf;

  logic       clk;
  logic       rstn;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;
  logic [1:0] bank_cnt;
  logic       trunc;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] exp_d[$];
  logic       exp_l[$];

  pingpong_frame_buf #(.BANK_NUM(2), .BANK_DEPTH(16), .DATA_WD(8)) u_dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .bank_cnt(bank_cnt), .trunc(trunc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted (bounded)
  task automatic send(input logic [7:0] d, input logic l);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int k = 0; k < 300; k++) begin
      if (in_ready) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic push_exp(input logic [7:0] d, input logic l);
    exp_d.push_back(d);
    exp_l.push_back(l);
  endtask

  // Consume n beats against the expectation queues (out_ready must be high)
  task automatic drain(input int n, input int budget, input bit nogap, input bit rdy_chk,
                       input string tag);
    int   got;
    bit   started;
    bit   seen_last;
    logic [7:0] ed;
    logic el;
    got = 0; started = 1'b0; seen_last = 1'b0;
    for (int c = 0; c < budget && got < n; c++) begin
      if (out_valid) begin
        ed = exp_d.pop_front();
        el = exp_l.pop_front();
        chk({tag, "_data"}, 32'(out_data), 32'(ed));
        chk({tag, "_last"}, 32'(out_last), 32'(el));
        if (rdy_chk && !seen_last) chk({tag, "_rdy_lo"}, 32'(in_ready), 32'd0);
        got++;
        started = 1'b1;
        if (out_last && !seen_last) begin
          seen_last = 1'b1;
          tick();
          if (rdy_chk) chk({tag, "_rdy_hi"}, 32'(in_ready), 32'd1);
          continue;
        end
      end else if (nogap && started) begin
        chk({tag, "_gap"}, 32'd0, 32'd1);
      end
      tick();
    end
    chk({tag, "_count"}, 32'(got), 32'(n));
  endtask

  initial begin
    int c0;
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_bank_cnt", 32'(bank_cnt), 32'd0);
    chk("rst_trunc", 32'(trunc), 32'd0);

    // 4-beat frame, store-and-forward
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h10 + i); in_last = (i == 3);
      chk("t1_sf_valid", 32'(out_valid), 32'd0);
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("t1_valid_up", 32'(out_valid), 32'd1);
    chk("t1_cnt_1", 32'(bank_cnt), 32'd1);
    for (int i = 0; i < 4; i++) push_exp(8'(8'h10 + i), i == 3);
    drain(4, 10, 1'b1, 1'b0, "t1");
    chk("t1_cnt_0", 32'(bank_cnt), 32'd0);
    chk("t1_valid_dn", 32'(out_valid), 32'd0);

    // Backpressure: both banks full, third frame waits for first release
    out_ready = 1'b0;
    for (int f = 0; f < 2; f++)
      for (int j = 0; j < 5; j++) send(8'(8'h20 + 5*f + j), j == 4);
    chk("t2_ready_lo", 32'(in_ready), 32'd0);
    chk("t2_cnt_2", 32'(bank_cnt), 32'd2);
    for (int i = 0; i < 15; i++) push_exp(8'(8'h20 + i), (i % 5) == 4);
    out_ready = 1'b1;
    fork
      for (int j = 0; j < 5; j++) send(8'(8'h2A + j), j == 4);
      drain(15, 200, 1'b0, 1'b1, "t2");
    join
    chk("t2_cnt_0", 32'(bank_cnt), 32'd0);

    // Truncation at BANK_DEPTH
    for (int i = 0; i < 20; i++) push_exp(8'(i), (i == 15) || (i == 19));
    fork
      for (int i = 0; i < 20; i++) begin
        send(8'(i), i == 19);
        chk($sformatf("t3_trunc_%0d", i), 32'(trunc), 32'(i == 15));
      end
      drain(20, 200, 1'b1, 1'b0, "t3");
    join
    chk("t3_cnt_0", 32'(bank_cnt), 32'd0);

    // Back-to-back 1-beat frames at full rate
    for (int i = 0; i < 8; i++) push_exp(8'(8'h40 + i), 1'b1);
    fork
      begin
        c0 = cyc;
        for (int i = 0; i < 8; i++) send(8'(8'h40 + i), 1'b1);
        chk("t4_wr_cycles", 32'(cyc - c0), 32'd8);
      end
      drain(8, 50, 1'b1, 1'b0, "t4");
    join

    // Flush with one full bank and one partial bank
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) send(8'(8'h50 + j), j == 2);
    send(8'h60, 1'b0);
    send(8'h61, 1'b0);
    chk("t5_pre_cnt", 32'(bank_cnt), 32'd1);
    chk("t5_pre_data", 32'(out_data), 32'h50);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h62; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_cnt", 32'(bank_cnt), 32'd0);
    chk("t5_ready", 32'(in_ready), 32'd1);
    chk("t5_trunc", 32'(trunc), 32'd0);
    send(8'h70, 1'b0);
    send(8'h71, 1'b1);
    chk("t5_post_cnt", 32'(bank_cnt), 32'd1);
    push_exp(8'h70, 1'b0);
    push_exp(8'h71, 1'b1);
    out_ready = 1'b1;
    drain(2, 10, 1'b1, 1'b0, "t5");
    chk("t5_end_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-drain
    out_ready = 1'b0;
    for (int j = 0; j < 4; j++) send(8'(8'h80 + j), j == 3);
    out_ready = 1'b1;
    tick();
    chk("t6_mid_data", 32'(out_data), 32'h81);
    #3;
    rstn = 1'b0;
    #1;
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_cnt", 32'(bank_cnt), 32'd0);
    chk("t6_ready", 32'(in_ready), 32'd1);
    chk("t6_last", 32'(out_last), 32'd0);
    out_ready = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // Single-beat frame after reset
    send(8'h90, 1'b1);
    chk("t7_valid", 32'(out_valid), 32'd1);
    chk("t7_data", 32'(out_data), 32'h90);
    chk("t7_last", 32'(out_last), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("t7_empty", 32'(out_valid), 32'd0);
    chk("t7_cnt", 32'(bank_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pingpong_frame_buf.md
Name: pingpong_frame_buf

Overview:
- Multi-bank ping-pong frame buffer with valid/ready handshakes on both sides.
- Accumulates whole frames (beat streams delimited by last) into BANK_NUM banks of BANK_DEPTH beats each.
- A bank is released to the reader only once its frame is complete, so downstream sees contiguous, gap-free frames.
- Sits between a bursty producer and a frame-oriented consumer; generalises the single-beat ping-pong slot buffer to frames, N banks, and flush/truncation handling.

Parameters:
BANK_NUM, 2, number of banks (>=1); bank indices wrap BANK_NUM-1 -> 0
BANK_DEPTH, 16, beats per bank (>=2); max frame length
DATA_WD, 8, data beat width in bits

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of all banks and pointers
in_valid  in  1  producer beat valid
in_data  in  DATA_WD  producer beat data
in_last  in  1  final beat of frame
in_ready  out  1  buffer can accept a beat
out_valid  out  1  beat available to consumer
out_data  out  DATA_WD  consumer beat data
out_last  out  1  final beat of current frame
out_ready  in  1  consumer accepts beat
bank_cnt  out  $clog2(BANK_NUM+1)  number of closed, undrained banks
trunc  out  1  one-cycle pulse: a frame was force-closed at BANK_DEPTH

Behaviour:
- Reset (async assert, sync release): all bank_full bits 0; wr_bank, wr_addr, rd_bank, rd_addr all 0.
- Outputs at reset: in_ready=1, out_valid=0, out_last=0, bank_cnt=0, trunc=0. out_data is don't-care when out_valid=0.
- Memory contents are not reset.
- Handshakes: fire_in = in_valid & in_ready; fire_out = out_valid & out_ready.
- Valid must not depend on ready on either side. out_valid/out_data/out_last hold stable while out_valid & !out_ready.

Write side:
- in_ready = !bank_full[wr_bank].
- On fire_in: store in_data at bank[wr_bank][wr_addr] and increment wr_addr.
- Close condition: in_last=1, or wr_addr==BANK_DEPTH-1.
- On close: set bank_full[wr_bank]; record len[wr_bank] = wr_addr+1; reset wr_addr to 0; advance wr_bank with wrap.
- Close caused by wr_addr==BANK_DEPTH-1 with in_last=0: trunc=1 on the next cycle (registered pulse). Beats that follow start a new frame in the next bank.

Read side:
- out_valid = bank_full[rd_bank].
- out_data = bank[rd_bank][rd_addr] (combinational read of the registered array).
- out_last = out_valid & (rd_addr == len[rd_bank]-1).
- On fire_out: increment rd_addr. If out_last: clear bank_full[rd_bank], reset rd_addr to 0, advance rd_bank with wrap.

Latency and occupancy:
- The first beat of a frame reaches out_valid no earlier than the cycle after its closing beat's fire_in (store-and-forward).
- bank_cnt = popcount(bank_full), registered. It increments on close and decrements on final read; it is unchanged if both happen in the same cycle.

Boundary conditions:
- Simultaneous close of bank A and release of bank B in one cycle: both take effect.
- The same bank cannot be written and read at once: the writer only enters non-full banks, the reader only full banks.
- All banks full: in_ready=0 until the first release; in_ready rises the cycle after that bank's out_last handshake.
- BANK_NUM=1: strict alternation between fill and drain phases.
- Single-beat frame (in_last on the first beat): len=1, and out_last=1 on its only beat.
- flush=1:
  - Next cycle: all bank_full=0, all pointers 0, bank_cnt=0, out_valid=0, in_ready=1.
  - Any partially written frame is discarded.
  - flush overrides same-cycle fire_in and fire_out. Data is still presented, but the state updates from those handshakes are discarded.
  - trunc is not generated in the flush cycle.
- rstn asserted mid-frame: immediate return to reset state; partial frames lost.

Test Plan:
- BANK_NUM=2, DEPTH=16: write 4-beat frame 0x10..0x13 (last on 0x13), out_ready=1 -> out_valid rises 1 cycle after last write; outputs 0x10..0x13 with out_last only on 0x13; bank_cnt 0->1->0.
- Write 3 frames of 5 beats with out_ready=0 -> in_ready=0 after the 2nd frame closes, bank_cnt=2. Raise out_ready -> after the first out_last handshake, in_ready=1 next cycle; 3rd frame accepted and all 15 beats arrive in order.
- Write 20 beats with no last (0x00..0x13) -> trunc pulses 1 cycle after beat 0x0F. Frame 1 = 0x00..0x0F with out_last on 0x0F; frame 2 = 0x10..0x13 with out_last on 0x13.
- Continuous streaming of 1-beat frames with in_valid=out_ready=1 -> every beat delivered with out_last=1, sustained throughput of one beat per cycle after the initial fill, no drops.
- Mid-frame (bank0 full, bank1 holding 2 beats) assert flush for 1 cycle with in_valid=out_ready=1 -> next cycle out_valid=0, bank_cnt=0, in_ready=1. The next frame written reads back from bank0, and no stale data appears.
- Assert rstn=0 asynchronously mid-drain -> out_valid=0, bank_cnt=0, in_ready=1 immediately, with no clock edge required.
